// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings and pattern helpers for the LED sequencer.
//   mode_e       - pattern mode encoding (matches the 2-bit mode_sel/mode ports)
//   state_e      - sequencer FSM state encoding (also exposed on dbg_state)
//   INIT_*       - pattern loaded when a mode is (re)selected
//   init_pattern - init pattern for a mode
//   next_pattern - one pattern step plus the updated BOUNCE direction
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [7:0] INIT_ALT    = 8'h55;
  localparam logic [7:0] INIT_CHASE  = 8'h01;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;
  localparam logic [7:0] INIT_COUNT  = 8'h00;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic [7:0] pattern;
    logic       dir;
  } step_t;

  function automatic logic [7:0] init_pattern(input mode_e m);
    logic [7:0] p;
    case (m)
      MODE_ALT:    p = INIT_ALT;
      MODE_CHASE:  p = INIT_CHASE;
      MODE_BOUNCE: p = INIT_BOUNCE;
      default:     p = INIT_COUNT;
    endcase
    return p;
  endfunction

  function automatic step_t next_pattern(input mode_e m, input logic [7:0] p,
                                         input logic dir);
    step_t s;
    s.pattern = p;
    s.dir     = dir;
    case (m)
      MODE_ALT:   s.pattern = ~p;
      MODE_CHASE: s.pattern = {p[6:0], p[7]};
      MODE_BOUNCE: begin
        // Direction flips on the step that lands on an end LED, so each
        // end LED is shown for exactly one step per turn.
        if (dir == DIR_UP) begin
          s.pattern = {p[6:0], 1'b0};
          if (s.pattern == 8'h80) s.dir = DIR_DOWN;
        end else begin
          s.pattern = {1'b0, p[7:1]};
          if (s.pattern == 8'h01) s.dir = DIR_UP;
        end
      end
      default:    s.pattern = p + 8'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// led_tick_gen: programmable prescaler for the LED step rate.
//   clk, rst  - clock, asynchronous active-low reset
//   en        - count enable (low freezes the count)
//   clr       - synchronous clear, wins over en
//   speed     - rate select, period L = max(TICK_DIV >> speed, 1)
//   tick      - combinational strobe: the count wraps on this edge
module led_tick_gen
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int DIV_W    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [DIV_W-1:0] DIV = DIV_W'(TICK_DIV);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] last;

  always_comb begin
    period = DIV >> speed;
    if (period == '0) period = ONE;
    last = period - ONE;
    // >= rather than == so a speed increase never lets the count run past
    // the new limit and wrap through the full counter range.
    tick  = en && (cnt_q >= last);
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer, sole driver of the prled bank.
//   clk, rst   - system clock, asynchronous active-low reset
//   mode_req   - mode-change request, mode_sel - requested mode
//   speed      - step-rate select, pause - freeze pattern and prescaler
//   mode_ack   - handshake acknowledge
//   tick       - one-cycle pulse coincident with each new prled value
//   mode       - active mode, prled - LED drive (1 = on)
//   dbg_state  - current FSM state
//
// Mode handshake (four-phase): the requester raises mode_req with mode_sel
// stable; mode_ack rises on the next edge with the new mode and its init
// pattern already applied; the requester then drops mode_req and mode_ack
// falls on the next edge. mode_sel is only sampled on the edge that enters
// ACK.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int DIV_W    = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [1:0] mode_sel,
  input  logic [1:0] speed,
  input  logic       pause,
  output logic       mode_ack,
  output logic       tick,
  output logic [1:0] mode,
  output logic [7:0] prled,
  output logic [1:0] dbg_state
);

  state_e     state_q;
  mode_e      mode_q;
  logic [7:0] prled_q;
  logic       dir_q;
  logic       tick_q;
  logic       ack_q;

  logic       gen_en;
  logic       gen_clr;
  logic       step_tick;
  step_t      step_d;
  mode_e      mode_sel_e;

  assign mode_sel_e = mode_e'(mode_sel);

  // The prescaler only advances in RUN when nothing higher priority (a
  // request or a pause) claims this edge; a request also zeroes it.
  assign gen_en  = (state_q == ST_RUN) && !mode_req && !pause;
  assign gen_clr = (state_q != ST_ACK) && mode_req;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (gen_en),
    .clr  (gen_clr),
    .speed(speed),
    .tick (step_tick)
  );

  assign step_d = next_pattern(mode_q, prled_q, dir_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      mode_q  <= MODE_ALT;
      prled_q <= INIT_ALT;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_RUN, ST_HOLD: begin
          if (mode_req) begin
            state_q <= ST_ACK;
            mode_q  <= mode_sel_e;
            prled_q <= init_pattern(mode_sel_e);
            dir_q   <= DIR_UP;
            ack_q   <= 1'b1;
          end else if (state_q == ST_RUN) begin
            if (pause) begin
              state_q <= ST_HOLD;
            end else if (step_tick) begin
              prled_q <= step_d.pattern;
              dir_q   <= step_d.dir;
              tick_q  <= 1'b1;
            end
          end else if (!pause) begin
            state_q <= ST_RUN;
          end
        end
        ST_ACK: begin
          if (!mode_req) begin
            ack_q   <= 1'b0;
            state_q <= pause ? ST_HOLD : ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign mode_ack  = ack_q;
  assign tick      = tick_q;
  assign mode      = mode_q;
  assign prled     = prled_q;
  assign dbg_state = state_q;

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED pattern sequencer for the 8-LED bank (`prled`) on the gm-proto-e1 board, clocked from the 10 MHz system clock.
- A programmable prescaler generates the step tick.
- A small FSM selects among four patterns: alternate, chase, bounce and binary count.
- A four-phase req/ack handshake lets another block (button handler, UART command decoder) switch modes safely.
- It replaces the fixed-rate blinker as the single owner of `prled`.

## Interface
- `TICK_DIV`, default 5000000: base step period in clock cycles (2 Hz at 10 MHz); must be ≥ 1.
- `DIV_W`, default 23: prescaler counter width; must satisfy 2^DIV_W > TICK_DIV.
- `clk`  in  1  system clock (10 MHz), all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mode_req`  in  1  mode-change request, held high until `mode_ack` is seen.
- `mode_sel`  in  2  requested mode, stable while `mode_req`=1: 0 ALT, 1 CHASE, 2 BOUNCE, 3 COUNT.
- `speed`  in  2  rate select; step period L = max(TICK_DIV >> speed, 1).
- `pause`  in  1  freeze pattern and prescaler while high.
- `mode_ack`  out  1  handshake acknowledge.
- `tick`  out  1  one-cycle pulse on every pattern step.
- `mode`  out  2  currently active mode.
- `prled`  out  8  LED drive, 1 = on.

## Operation
- Reset (`rst`=0) forces all outputs immediately:
  - state RUN, `mode`=ALT, `prled`=8'h55, prescaler=0, `tick`=0, `mode_ack`=0.
  - BOUNCE direction = up.
- FSM states:
  - RUN: prescaler counts. When count ≥ L−1: count←0, `tick`←1, `prled`←next(mode). Otherwise count+1, `tick`←0.
  - HOLD: prescaler, pattern and `tick` frozen (`tick`=0).
  - ACK: `mode_ack`=1, prescaler held at 0.
- Transitions, evaluated in priority order each cycle:
  - RUN or HOLD with `mode_req`=1 → ACK. On that edge: `mode`←`mode_sel`, `prled`←init(`mode_sel`), prescaler←0, BOUNCE dir←up, `tick`←0.
  - RUN with `pause`=1 → HOLD. HOLD with `pause`=0 → RUN.
  - ACK with `mode_req`=0 → RUN if `pause`=0, else HOLD. `mode_ack` drops on the same edge.
- Init patterns: ALT 8'h55, CHASE 8'h01, BOUNCE 8'h01, COUNT 8'h00.
- Step rules:
  - ALT: invert.
  - CHASE: rotate left; 8'h80 → 8'h01.
  - BOUNCE: shift left while dir=up. On reaching 8'h80, set dir=down; shift right until 8'h01, then set dir=up. Exactly one LED is on at any time; the end LEDs are each shown once per turn.
  - COUNT: +1 modulo 256; 8'hFF → 8'h00.
- Re-requesting the mode that is already active still reloads its init pattern.
- `speed` changes take effect immediately. Because the compare is ≥, a count already past the new L−1 produces a tick on the next edge, never a wrap through 2^DIV_W.
- `mode_sel` is sampled only on the RUN/HOLD→ACK edge. Changes during ACK are ignored.

## Timing
- From reset release in RUN: first step on the L-th rising edge, then every L cycles. `tick` is high in the same cycle that `prled` shows the new value.
- Mode switch: `mode_ack` rises on the first edge after `mode_req` is sampled high. `prled` shows the init pattern on that same edge.
- After `mode_req` falls, the first step follows L edges after leaving ACK.
- Pause latency: one edge. A tick due on the edge where `pause` is first sampled high is suppressed. On resume, counting continues from the held count.
- Reset mid-ACK: `mode_ack` clears asynchronously; mode returns to ALT. The requester must restart its handshake.

## Structure
- Package `led_seq_pkg` holds:
  - mode encoding (ALT/CHASE/BOUNCE/COUNT) and FSM state encoding;
  - the init-pattern constants;
  - a `next_pattern(mode, pattern, dir)` function returning the next pattern and direction.
- Sub-module `led_tick_gen` holds the prescaler: inputs `clk`, `rst`, `en`, `clr`, `speed`; output `tick`; parameters `TICK_DIV`, `DIV_W`.
- FSM and pattern register live in `led_seq_ctrl`.

## Test plan
All scenarios use TICK_DIV=8, DIV_W=4, speed=0 unless stated.
1. Reset release → `prled`=55, AA, 55 at edges 8, 16, 24. `tick` is high exactly on those cycles, `mode_ack`=0.
2. Request CHASE (req high until ack, then low) → ack after 1 edge, `prled`=01. Then 02, 04 … 80, 01 every 8 cycles.
3. BOUNCE over 16 steps → 02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04. COUNT from FF steps to 00.
4. speed=3 (L=1) → step every cycle. Switching speed 0→2 with count=5 (L=2) → tick on the next edge, then every 2 cycles.
5. `pause`=1 for 20 cycles mid-count at count=3 → `prled` and `tick` frozen. Request COUNT while paused → ack, `prled`=00, stays in HOLD after req drops. Release pause → first step 8 edges later.
6. Assert `rst` low while `mode_ack`=1 in BOUNCE → outputs are reset values immediately. After release, the step sequence matches scenario 1.
